pipelined_decode_ctrl: RTL and testbench
========================================

Name: pipelined_decode_ctrl

Overview:
Registered, handshaked successor to the combinational control decoder.
- Decodes one 32-bit instruction per cycle into a control word held in an output pipeline register.
- Covers the full ISA: R-type ALU plus mul/div, addi, lw, sw, j, jal, jr, bne, blt.
- Inserts load-use bubbles and stalls while the multdiv unit is busy.
- Sits between the fetch/decode latch and the execute stage.

Parameters:
OPW, 5, opcode width (instr[31:27])
FUNCW, 5, ALU func width (instr[6:2]); also the aluop width
REGW, 5, register address width
LINK_REG, 31, destination register written by jal

Ports:
clock  in  1  system clock
reset_n  in  1  synchronous active-low reset
in_valid  in  1  instr is valid
in_ready  out  1  block accepts instr this cycle
instr  in  32  instruction word
out_valid  out  1  control word valid
out_ready  in  1  execute stage accepts the control word
rwe  out  1  register write enable
rdst  out  1  0 = R-type operand select, 1 = I-type
aluinb  out  1  ALU B operand is the immediate
aluop  out  FUNCW  ALU operation
dmwe  out  1  data-memory write enable
rwd  out  1  writeback source is memory
jump  out  2  00 none, 01 j, 10 jal, 11 jr
branch  out  2  00 none, 01 bne, 10 blt
rd_addr  out  REGW  writeback register
illegal  out  1  opcode or func not recognised
md_start  out  1  one-cycle multdiv start pulse
md_is_div  out  1  1 = div, 0 = mul
md_done  in  1  multdiv result ready

Behaviour:
- Reset (clock edge with reset_n=0), from any state including MD_WAIT:
  - out_valid, in_ready, every control output and md_start go to 0.
  - FSM goes to RUN.
- Opcode decode:
  - R-type 00000
  - j 00001, bne 00010, jal 00011, jr 00100
  - addi 00101, blt 00110, sw 00111, lw 01000
- R-type func decode: add 00000, sub 00001, and 00010, or 00011, sll 00100, sra 00101, mul 00110, div 00111.
- Control-word rules:
  - aluop = func for R-type; 00000 for addi, lw and sw; 00001 for bne and blt.
  - rwe = 1 for R-type, addi, lw and jal.
  - rwe is forced to 0 when the destination is register 0.
  - For jal, rd_addr = LINK_REG; otherwise rd_addr = instr[26:22].
- Illegal opcode or func:
  - illegal = 1.
  - rwe, dmwe, jump, branch and md_start are all 0.
  - The word still transfers normally.
- Handshake:
  - Input transfers when in_valid & in_ready; output transfers when out_valid & out_ready.
  - Latency is 1: an accepted instr appears in the output register on the next cycle.
  - in_ready = (~out_valid | out_ready) & state==RUN & ~hazard.
  - The output register holds its value while out_valid & ~out_ready.
- FSM states: RUN, MD_WAIT.
  - RUN → MD_WAIT when a mul/div is accepted.
  - Load cycle for that instruction: md_start = 1 for exactly that one cycle; out_valid = 0.
  - MD_WAIT: in_ready = 0; md_done is sampled only in this state.
  - md_done = 1 in MD_WAIT: out_valid goes to 1 with the mul/div word, FSM returns to RUN.
  - In RUN, md_done is ignored.
- Load-use hazard (when compiled in):
  - Sources checked: rs = instr[21:17] always; rt = instr[16:12] for R-type; rd for sw, bne, blt and jr.
  - Condition: the output register holds a valid lw with rd≠0, and the incoming instr reads that rd.
  - Effect: in_ready = 0. When the lw transfers out, the register loads a bubble (out_valid = 0).
  - Result: exactly one idle cycle, then the dependent instr is accepted.
- Simultaneous output transfer and input accept: the register loads the new word with no gap.

Optional Feature:
HAZARD_DETECT_EN
- Defined: load-use bubble insertion exactly as in Behaviour.
- Undefined: hazard is tied to 0. Dependent instructions issue back-to-back and software must schedule around load-use.

Test Plan:
- Reset: reset_n=0 for 2 cycles with in_valid=1 → out_valid=0, in_ready=0. The cycle after reset_n=1, in_ready=1.
- Add then addi: add r3,r1,r2 then addi r4,r1,5, out_ready=1 → 1 cycle later rwe=1, rdst=0, aluop=00000; next cycle rdst=1, aluinb=1, rwe=1.
- Load-use:
  - lw r5 then add r6,r5,r1 with HAZARD_DETECT_EN → one cycle with out_valid=0 between the two words.
  - Same sequence without the macro → no gap.
- Multdiv:
  - mul r7,r1,r2 → md_start=1 for 1 cycle, md_is_div=0, in_ready=0.
  - md_done asserted 5 cycles later → out_valid=1 that cycle with aluop=00110; in_ready=1 the next cycle.
- Jal and register 0: jal → jump=10, rwe=1, rd_addr=31. add r0,r1,r2 → rwe=0. Opcode 11111 → illegal=1, dmwe=0.
- Backpressure and reset in MD_WAIT:
  - out_ready=0 for 3 cycles → control word stable, in_ready=0.
  - Reset during MD_WAIT → state RUN, out_valid=0, md_start=0.

Source files
------------

// File: rtl/pipelined_decode_ctrl.sv
// Registered, handshaked instruction decoder with multdiv stall and load-use bubble.
// Optional HAZARD_DETECT_EN compiles in the load-use interlock; otherwise hazard is tied low.
module pipelined_decode_ctrl #(
    parameter int unsigned OPW      = 5,
    parameter int unsigned FUNCW    = 5,
    parameter int unsigned REGW     = 5,
    parameter int unsigned LINK_REG = 31
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      instr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             rwe,
    output logic             rdst,
    output logic             aluinb,
    output logic [FUNCW-1:0] aluop,
    output logic             dmwe,
    output logic             rwd,
    output logic [1:0]       jump,
    output logic [1:0]       branch,
    output logic [REGW-1:0]  rd_addr,
    output logic             illegal,
    output logic             md_start,
    output logic             md_is_div,
    input  logic             md_done
);

    typedef enum logic {RUN, MD_WAIT} state_t;

    localparam logic [OPW-1:0] OP_R    = OPW'(0);
    localparam logic [OPW-1:0] OP_J    = OPW'(1);
    localparam logic [OPW-1:0] OP_BNE  = OPW'(2);
    localparam logic [OPW-1:0] OP_JAL  = OPW'(3);
    localparam logic [OPW-1:0] OP_JR   = OPW'(4);
    localparam logic [OPW-1:0] OP_ADDI = OPW'(5);
    localparam logic [OPW-1:0] OP_BLT  = OPW'(6);
    localparam logic [OPW-1:0] OP_SW   = OPW'(7);
    localparam logic [OPW-1:0] OP_LW   = OPW'(8);

    localparam logic [FUNCW-1:0] F_SUB = FUNCW'(1);
    localparam logic [FUNCW-1:0] F_MUL = FUNCW'(6);
    localparam logic [FUNCW-1:0] F_DIV = FUNCW'(7);

    state_t           state_q, state_d;
    logic             active_q;
    logic             ov_d, md_start_d, load_word, accept, hazard;
    logic [OPW-1:0]   op;
    logic [FUNCW-1:0] func;
    logic [REGW-1:0]  rd_f;

    logic             dec_rwe, dec_rdst, dec_aluinb, dec_dmwe, dec_rwd;
    logic             dec_illegal, dec_md, dec_div;
    logic [FUNCW-1:0] dec_aluop;
    logic [1:0]       dec_jump, dec_branch;
    logic [REGW-1:0]  dec_rd;

    logic unused_bits;
    assign unused_bits = ^{instr[11:7], instr[1:0]};

    // Instruction decode into the next control word
    always_comb begin
        op          = instr[31 -: OPW];
        func        = instr[2 +: FUNCW];
        rd_f        = instr[26 -: REGW];
        dec_rwe     = 1'b0;
        dec_rdst    = 1'b0;
        dec_aluinb  = 1'b0;
        dec_dmwe    = 1'b0;
        dec_rwd     = 1'b0;
        dec_illegal = 1'b0;
        dec_md      = 1'b0;
        dec_div     = 1'b0;
        dec_aluop   = '0;
        dec_jump    = 2'b00;
        dec_branch  = 2'b00;
        dec_rd      = rd_f;
        case (op)
            OP_R: begin
                if (func <= F_DIV) begin
                    dec_rwe   = 1'b1;
                    dec_aluop = func;
                    dec_md    = (func == F_MUL) || (func == F_DIV);
                    dec_div   = (func == F_DIV);
                end else begin
                    dec_illegal = 1'b1;
                end
            end
            OP_J:    dec_jump = 2'b01;
            OP_BNE:  begin dec_branch = 2'b01; dec_aluop = F_SUB; dec_rdst = 1'b1; end
            OP_JAL:  begin dec_jump = 2'b10; dec_rwe = 1'b1; dec_rd = REGW'(LINK_REG); end
            OP_JR:   begin dec_jump = 2'b11; dec_rdst = 1'b1; end
            OP_ADDI: begin dec_rwe = 1'b1; dec_rdst = 1'b1; dec_aluinb = 1'b1; end
            OP_BLT:  begin dec_branch = 2'b10; dec_aluop = F_SUB; dec_rdst = 1'b1; end
            OP_SW:   begin dec_dmwe = 1'b1; dec_rdst = 1'b1; dec_aluinb = 1'b1; end
            OP_LW:   begin dec_rwe = 1'b1; dec_rdst = 1'b1; dec_aluinb = 1'b1; dec_rwd = 1'b1; end
            default: dec_illegal = 1'b1;
        endcase
        if (dec_illegal) begin
            dec_rwe    = 1'b0;
            dec_dmwe   = 1'b0;
            dec_jump   = 2'b00;
            dec_branch = 2'b00;
            dec_md     = 1'b0;
            dec_div    = 1'b0;
        end
        if (dec_rd == '0) begin
            dec_rwe = 1'b0;
        end
    end

`ifdef HAZARD_DETECT_EN
    logic            ld_q, uses_rt, uses_rd;
    logic [REGW-1:0] rs_f, rt_f;

    // Tracks whether the word in the output register is a load
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            ld_q <= 1'b0;
        end else if (load_word) begin
            ld_q <= (op == OP_LW);
        end
    end

    always_comb begin
        rs_f    = instr[21 -: REGW];
        rt_f    = instr[16 -: REGW];
        uses_rt = (op == OP_R);
        uses_rd = (op == OP_SW) || (op == OP_BNE) || (op == OP_BLT) || (op == OP_JR);
        hazard  = in_valid && out_valid && ld_q && (rd_addr != '0) &&
                  ((rs_f == rd_addr) || (uses_rt && (rt_f == rd_addr)) ||
                   (uses_rd && (rd_f == rd_addr)));
    end
`else
    logic unused_src;
    assign unused_src = ^instr[21:12];
    assign hazard     = 1'b0;
`endif

    assign in_ready = active_q && (!out_valid || out_ready) && (state_q == RUN) && !hazard;
    assign accept   = in_valid && in_ready;

    // Next state, output-register load and valid/start control
    always_comb begin
        state_d    = state_q;
        ov_d       = out_valid;
        md_start_d = 1'b0;
        load_word  = 1'b0;
        case (state_q)
            RUN: begin
                if (accept) begin
                    load_word = 1'b1;
                    if (dec_md) begin
                        ov_d       = 1'b0;
                        md_start_d = 1'b1;
                        state_d    = MD_WAIT;
                    end else begin
                        ov_d = 1'b1;
                    end
                end else if (out_valid && out_ready) begin
                    ov_d = 1'b0;
                end
            end
            MD_WAIT: begin
                if (md_done) begin
                    ov_d    = 1'b1;
                    state_d = RUN;
                end
            end
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q   <= RUN;
            active_q  <= 1'b0;
            out_valid <= 1'b0;
            md_start  <= 1'b0;
            rwe       <= 1'b0;
            rdst      <= 1'b0;
            aluinb    <= 1'b0;
            aluop     <= '0;
            dmwe      <= 1'b0;
            rwd       <= 1'b0;
            jump      <= 2'b00;
            branch    <= 2'b00;
            rd_addr   <= '0;
            illegal   <= 1'b0;
            md_is_div <= 1'b0;
        end else begin
            state_q   <= state_d;
            active_q  <= 1'b1;
            out_valid <= ov_d;
            md_start  <= md_start_d;
            if (load_word) begin
                rwe       <= dec_rwe;
                rdst      <= dec_rdst;
                aluinb    <= dec_aluinb;
                aluop     <= dec_aluop;
                dmwe      <= dec_dmwe;
                rwd       <= dec_rwd;
                jump      <= dec_jump;
                branch    <= dec_branch;
                rd_addr   <= dec_rd;
                illegal   <= dec_illegal;
                md_is_div <= dec_div;
            end
        end
    end

endmodule

// File: tb/tb_pipelined_decode_ctrl.sv
// Directed self-checking bench for pipelined_decode_ctrl; load-use expectations follow HAZARD_DETECT_EN.
module tb_pipelined_decode_ctrl;

    logic        clock = 1'b0;
    logic        reset_n, in_valid, in_ready, out_valid, out_ready;
    logic [31:0] instr;
    logic        rwe, rdst, aluinb, dmwe, rwd, illegal, md_start, md_is_div, md_done;
    logic [4:0]  aluop, rd_addr;
    logic [1:0]  jump, branch;
    int          n_checks = 0;
    int          n_errors = 0;

    pipelined_decode_ctrl dut (
        .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
        .instr(instr), .out_valid(out_valid), .out_ready(out_ready), .rwe(rwe),
        .rdst(rdst), .aluinb(aluinb), .aluop(aluop), .dmwe(dmwe), .rwd(rwd),
        .jump(jump), .branch(branch), .rd_addr(rd_addr), .illegal(illegal),
        .md_start(md_start), .md_is_div(md_is_div), .md_done(md_done)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] rtype(input logic [4:0] rd, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [4:0] fn);
        return {5'd0, rd, rs, rt, 5'd0, fn, 2'b00};
    endfunction

    function automatic logic [31:0] itype(input logic [4:0] op, input logic [4:0] rd,
                                          input logic [4:0] rs, input logic [16:0] imm);
        return {op, rd, rs, imm};
    endfunction

    // Present one instruction for a single edge, then stop at the next falling edge
    task automatic issue(input logic [31:0] word);
        in_valid = 1'b1;
        instr    = word;
        @(posedge clock); #1;
        in_valid = 1'b0;
        @(negedge clock);
    endtask

    task automatic step;
        @(posedge clock); #1;
        @(negedge clock);
    endtask

    initial begin
        reset_n   = 1'b0;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        md_done   = 1'b0;
        instr     = rtype(5'd3, 5'd1, 5'd2, 5'd0);
        repeat (2) @(posedge clock);
        #1;
        @(negedge clock);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_md_start", 32'(md_start), 32'd0);
        check("rst_rwe", 32'(rwe), 32'd0);
        reset_n  = 1'b1;
        in_valid = 1'b0;
        step();
        check("post_rst_in_ready", 32'(in_ready), 32'd1);

        // add r3,r1,r2 followed back-to-back by addi r4,r1,5
        in_valid = 1'b1;
        instr    = rtype(5'd3, 5'd1, 5'd2, 5'd0);
        @(posedge clock); #1;
        instr = itype(5'd5, 5'd4, 5'd1, 17'd5);
        @(negedge clock);
        check("add_valid", 32'(out_valid), 32'd1);
        check("add_rwe", 32'(rwe), 32'd1);
        check("add_rdst", 32'(rdst), 32'd0);
        check("add_aluop", 32'(aluop), 32'd0);
        check("add_rd", 32'(rd_addr), 32'd3);
        @(posedge clock); #1;
        in_valid = 1'b0;
        @(negedge clock);
        check("addi_valid", 32'(out_valid), 32'd1);
        check("addi_rdst", 32'(rdst), 32'd1);
        check("addi_aluinb", 32'(aluinb), 32'd1);
        check("addi_rwe", 32'(rwe), 32'd1);
        check("addi_rd", 32'(rd_addr), 32'd4);
        step();
        check("drain_valid", 32'(out_valid), 32'd0);

        // lw r5 then add r6,r5,r1
        in_valid = 1'b1;
        instr    = itype(5'd8, 5'd5, 5'd1, 17'd0);
        @(posedge clock); #1;
        instr = rtype(5'd6, 5'd5, 5'd1, 5'd0);
        @(negedge clock);
        check("lw_valid", 32'(out_valid), 32'd1);
        check("lw_rwd", 32'(rwd), 32'd1);
        check("lw_rd", 32'(rd_addr), 32'd5);
`ifdef HAZARD_DETECT_EN
        check("lu_in_ready", 32'(in_ready), 32'd0);
        @(posedge clock); #1;
        @(negedge clock);
        check("lu_bubble", 32'(out_valid), 32'd0);
        check("lu_ready_after", 32'(in_ready), 32'd1);
        @(posedge clock); #1;
`else
        check("lu_in_ready", 32'(in_ready), 32'd1);
        @(posedge clock); #1;
`endif
        in_valid = 1'b0;
        @(negedge clock);
        check("lu_dep_valid", 32'(out_valid), 32'd1);
        check("lu_dep_rd", 32'(rd_addr), 32'd6);
        step();

        // md_done is ignored in RUN
        md_done = 1'b1;
        step();
        md_done = 1'b0;
        check("md_done_run", 32'(out_valid), 32'd0);

        // mul r7,r1,r2 with md_done five cycles after the start pulse
        issue(rtype(5'd7, 5'd1, 5'd2, 5'd6));
        check("mul_start", 32'(md_start), 32'd1);
        check("mul_is_div", 32'(md_is_div), 32'd0);
        check("mul_in_ready", 32'(in_ready), 32'd0);
        check("mul_hold_valid", 32'(out_valid), 32'd0);
        step();
        check("mul_start_pulse", 32'(md_start), 32'd0);
        check("mul_wait_ready", 32'(in_ready), 32'd0);
        repeat (3) step();
        check("mul_wait_valid", 32'(out_valid), 32'd0);
        md_done = 1'b1;
        @(posedge clock); #1;
        md_done = 1'b0;
        @(negedge clock);
        check("mul_done_valid", 32'(out_valid), 32'd1);
        check("mul_aluop", 32'(aluop), 32'd6);
        check("mul_rd", 32'(rd_addr), 32'd7);
        step();
        check("mul_next_ready", 32'(in_ready), 32'd1);

        // div r8 with md_done in the first wait cycle
        issue(rtype(5'd8, 5'd1, 5'd2, 5'd7));
        check("div_start", 32'(md_start), 32'd1);
        check("div_is_div", 32'(md_is_div), 32'd1);
        md_done = 1'b1;
        @(posedge clock); #1;
        md_done = 1'b0;
        @(negedge clock);
        check("div_valid", 32'(out_valid), 32'd1);
        check("div_aluop", 32'(aluop), 32'd7);

        // jal, writes to r0, illegal encodings and the remaining opcodes
        issue(itype(5'd3, 5'd5, 5'd0, 17'd100));
        check("jal_jump", 32'(jump), 32'd2);
        check("jal_rwe", 32'(rwe), 32'd1);
        check("jal_rd", 32'(rd_addr), 32'd31);
        issue(rtype(5'd0, 5'd1, 5'd2, 5'd0));
        check("r0_rwe", 32'(rwe), 32'd0);
        issue({5'b11111, 27'd0});
        check("illop_illegal", 32'(illegal), 32'd1);
        check("illop_dmwe", 32'(dmwe), 32'd0);
        check("illop_valid", 32'(out_valid), 32'd1);
        issue(rtype(5'd9, 5'd1, 5'd2, 5'd9));
        check("illfn_illegal", 32'(illegal), 32'd1);
        check("illfn_rwe", 32'(rwe), 32'd0);
        issue(itype(5'd7, 5'd2, 5'd1, 17'd4));
        check("sw_dmwe", 32'(dmwe), 32'd1);
        check("sw_rwe", 32'(rwe), 32'd0);
        check("sw_illegal", 32'(illegal), 32'd0);
        issue(itype(5'd2, 5'd2, 5'd1, 17'd8));
        check("bne_branch", 32'(branch), 32'd1);
        check("bne_aluop", 32'(aluop), 32'd1);
        issue(itype(5'd6, 5'd2, 5'd1, 17'd8));
        check("blt_branch", 32'(branch), 32'd2);
        issue(itype(5'd4, 5'd3, 5'd0, 17'd0));
        check("jr_jump", 32'(jump), 32'd3);
        check("jr_rwe", 32'(rwe), 32'd0);
        issue(itype(5'd1, 5'd0, 5'd0, 17'd12));
        check("j_jump", 32'(jump), 32'd1);

        // Backpressure: word must hold for three cycles
        issue(rtype(5'd9, 5'd1, 5'd2, 5'd3));
        out_ready = 1'b0;
        in_valid  = 1'b1;
        instr     = itype(5'd5, 5'd10, 5'd1, 17'd1);
        for (int i = 0; i < 3; i++) begin
            @(posedge clock); #1;
            @(negedge clock);
            check("bp_valid", 32'(out_valid), 32'd1);
            check("bp_rd", 32'(rd_addr), 32'd9);
            check("bp_aluop", 32'(aluop), 32'd3);
            check("bp_in_ready", 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        @(posedge clock); #1;
        in_valid = 1'b0;
        @(negedge clock);
        check("bp_next_rd", 32'(rd_addr), 32'd10);
        step();

        // Reset while waiting on the multdiv unit
        issue(rtype(5'd11, 5'd1, 5'd2, 5'd6));
        check("mdrst_start", 32'(md_start), 32'd1);
        reset_n = 1'b0;
        @(posedge clock); #1;
        reset_n = 1'b1;
        @(negedge clock);
        check("mdrst_valid", 32'(out_valid), 32'd0);
        check("mdrst_md_start", 32'(md_start), 32'd0);
        md_done = 1'b1;
        step();
        md_done = 1'b0;
        check("mdrst_run_ready", 32'(in_ready), 32'd1);
        check("mdrst_no_valid", 32'(out_valid), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
